uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- asynchronous serial receiver, LSB first, optional parity,
// one or two stop bits. Each bit is sampled once, near its centre, by a
// counter that is timed from the falling edge of the start bit.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   i_rx          serial line (asynchronous, idle high)
//   o_data        last received data word, held until the next frame
//   o_data_valid  one-cycle pulse when a frame completes
//   o_parity_err  parity mismatch of the frame flagged by o_data_valid
//   o_frame_err   a stop bit was sampled low in that frame
//   o_busy        receiver is inside a frame (state is not IDLE)
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int SAMPLES_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT        = SAMPLES_PER_BIT / 2;
  localparam int CNT_W           = $clog2(SAMPLES_PER_BIT + 1);
  localparam int BIT_W           = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP    = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [1:0]           stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 bit_end;

  // Odd parity expects the parity bit to be ~XOR(data), even expects XOR(data).
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                           input logic                 p);
    logic mismatch;
    mismatch = 1'b0;
    if (PARITY == 1) mismatch = (p == (^d));
    else if (PARITY == 2) mismatch = (p != (^d));
    return mismatch;
  endfunction

  assign bit_end = (cnt_q == CNT_BIT_END);
  assign o_busy  = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_s_q       <= rx_meta_q;
      // rx_prev_q follows rx_s_q in every state, so a start edge is only
      // seen after the line has been high (a held break never re-triggers).
      rx_prev_q    <= rx_s_q;
      o_data_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF_END) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              bit_q   <= '0;
              stop_q  <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PAR: begin
          if (bit_end) begin
            cnt_q   <= '0;
            perr_q  <= parity_mismatch(shift_q, rx_s_q);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_q == LAST_STOP) begin
              o_data       <= shift_q;
              o_parity_err <= perr_q;
              o_frame_err  <= ferr_q | ~rx_s_q;
              o_data_valid <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              stop_q <= stop_q + 2'd1;
              ferr_q <= ferr_q | ~rx_s_q;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: dut_a is 8N1, dut_b is 8E1; both at 10 clocks per bit.
module tb_uart_rx;

  localparam int SPB  = 10;
  localparam int HALF = 5;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic rst_seen = 1'b1;
  bit   run = 1'b0;

  exp_t q[2][$];
  exp_t last[2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
            .STOP_BITS(1), .PARITY(0)) dut_a (
    .clk(clk), .rst(rst), .i_rx(rx_a), .o_data(data_a), .o_data_valid(vld_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_busy(busy_a));

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
            .STOP_BITS(1), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .i_rx(rx_b), .o_data(data_b), .o_data_valid(vld_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_busy(busy_b));

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle compare against the frame scoreboard.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        string      nm;
        logic       v, b, pe, fe;
        logic [7:0] d;
        exp_t       e;
        nm = (i == 0) ? "a" : "b";
        v  = (i == 0) ? vld_a  : vld_b;
        b  = (i == 0) ? busy_a : busy_b;
        pe = (i == 0) ? perr_a : perr_b;
        fe = (i == 0) ? ferr_a : ferr_b;
        d  = (i == 0) ? data_a : data_b;
        if (rst_seen) begin
          last[i] = '{8'h00, 1'b0, 1'b0, 0, 0};
          q[i].delete();
        end
        if (v) begin
          if (q[i].size() == 0) begin
            chk({nm, "_unexpected_pulse"}, 1, 0);
          end else begin
            e = q[i].pop_front();
            chk({nm, "_latency_in_window"},
                int'(cyc >= e.due - 1 && cyc <= e.due + 1), 1);
            last[i] = e;
          end
        end else if (q[i].size() > 0 && cyc > q[i][0].due + 1) begin
          chk({nm, "_pulse_timeout"}, 0, 1);
          void'(q[i].pop_front());
        end
        if (q[i].size() > 0 && cyc >= q[i][0].start + 4 && cyc <= q[i][0].due - 2)
          chk({nm, "_busy_in_frame"}, int'(b), 1);
        chk({nm, "_data"}, int'(d), int'(last[i].data));
        chk({nm, "_parity_err"}, int'(pe), int'(last[i].perr));
        chk({nm, "_frame_err"}, int'(fe), int'(last[i].ferr));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
    idle(SPB);
  endtask

  // Sends one frame and records what the receiver must report for it.
  task automatic send(input int sel, input logic [7:0] d, input int has_par,
                      input logic pbit, input logic stop);
    exp_t e;
    int   nbits;
    nbits   = 8 + has_par + 1;
    e.data  = d;
    e.perr  = (has_par != 0) && ((($countones(d) + int'(pbit)) % 2) != 0);
    e.ferr  = ~stop;
    e.start = cyc;
    // Line falls now; rx_s falls 2 cycles later; then the latency formula.
    e.due   = cyc + 2 + HALF + nbits * SPB + 1;
    q[sel].push_back(e);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par != 0) drive_bit(sel, pbit);
    drive_bit(sel, stop);
  endtask

  initial begin
    logic [7:0] bits3c;
    bits3c = 8'h3C;
    idle(3);
    @(negedge clk);
    chk("reset_data_a", int'(data_a), 0);
    chk("reset_valid_a", int'(vld_a), 0);
    chk("reset_perr_a", int'(perr_a), 0);
    chk("reset_ferr_a", int'(ferr_a), 0);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b1;
    idle(5);

    // 0xA5 8N1
    send(0, 8'hA5, 0, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_a5_data", int'(data_a), 8'hA5);
    chk("lit_a5_ferr", int'(ferr_a), 0);
    @(posedge clk); #1;

    // Even parity: 0x03 has two ones, so a parity bit of 1 is wrong.
    send(1, 8'h03, 1, 1'b1, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_03_data", int'(data_b), 8'h03);
    chk("lit_03_perr_bad", int'(perr_b), 1);
    @(posedge clk); #1;
    send(1, 8'h03, 1, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_03_perr_good", int'(perr_b), 0);
    @(posedge clk); #1;

    // Low stop bit followed by a held break.
    send(0, 8'h55, 0, 1'b0, 1'b0);
    idle(30);
    @(negedge clk);
    chk("lit_55_ferr", int'(ferr_a), 1);
    chk("lit_55_data", int'(data_a), 8'h55);
    chk("break_not_busy", int'(busy_a), 0);
    @(posedge clk); #1;
    rx_a = 1'b1;
    idle(20);
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_5a_ferr", int'(ferr_a), 0);
    @(posedge clk); #1;

    // 3-cycle glitch on an idle line.
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    idle(6);
    @(negedge clk);
    chk("glitch_busy_cleared", int'(busy_a), 0);
    chk("glitch_data_held", int'(data_a), 8'h5A);
    @(posedge clk); #1;
    idle(20);

    // Back-to-back frames.
    send(0, 8'h00, 0, 1'b0, 1'b1);
    send(0, 8'hFF, 0, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_ff_data", int'(data_a), 8'hFF);
    @(posedge clk); #1;

    // Reset during data bit 3 (a high bit) of 0x3C.
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, bits3c[i]);
    rx_a = bits3c[3];
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rx_a = 1'b1;
    @(negedge clk);
    chk("rst_mid_data", int'(data_a), 0);
    chk("rst_mid_valid", int'(vld_a), 0);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_ferr", int'(ferr_a), 0);
    @(posedge clk); #1;
    idle(20);
    send(0, 8'h81, 0, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("lit_81_data", int'(data_a), 8'h81);
    @(posedge clk); #1;

    idle(30);
    chk("a_frames_pending", q[0].size(), 0);
    chk("b_frames_pending", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
